bsg_manycore_link_to_sdr_test_ctrl: RTL

Run controller sitting directly upstream of the manycore-link SDR test node.
- Drives the node's enable with a programmable burst/gap pattern until a target packet count is reached.
- Then waits for all returned packets to drain and reports pass/fail/timeout.
- Consumes the node's free-running sent/received counters and sticky error flag; all measurements are deltas relative to a baseline snapshot taken at start.

---
 rtl/bsg_manycore_link_to_sdr_test_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_link_to_sdr_test_ctrl.sv
// Run controller for the manycore-link SDR test node: paces the node enable in
// burst/gap pattern up to a packet target, then waits for returns and reports.
module bsg_manycore_link_to_sdr_test_ctrl #(
  parameter int count_width_p   = 32,
  parameter int gap_width_p     = 8,
  parameter int timeout_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [count_width_p-1:0]   num_packets_i,
  input  logic [gap_width_p-1:0]     burst_len_i,
  input  logic [gap_width_p-1:0]     gap_len_i,
  input  logic [timeout_width_p-1:0] timeout_i,
  output logic                       node_en_o,
  input  logic                       node_error_i,
  input  logic [count_width_p-1:0]   node_sent_i,
  input  logic [count_width_p-1:0]   node_received_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       timeout_o,
  output logic [count_width_p-1:0]   sent_count_o,
  output logic [count_width_p-1:0]   recv_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_e;

  state_e                     state_r, state_n;
  logic [count_width_p-1:0]   sent_base_r, recv_base_r, num_r;
  logic [gap_width_p-1:0]     burst_r, gap_r, burst_cnt_r, burst_cnt_n, gap_cnt_r, gap_cnt_n;
  logic [timeout_width_p-1:0] timeout_r, drain_cnt_r, drain_cnt_n;
  logic                       en_n, cap, fin, fin_to;

  // Modulo subtraction makes node counter wrap invisible.
  logic [count_width_p-1:0] sent_d, recv_d;
  logic                     reached;
  assign sent_d  = node_sent_i - sent_base_r;
  assign recv_d  = node_received_i - recv_base_r;
  assign reached = (sent_d >= num_r);

  always_comb begin
    state_n     = state_r;
    en_n        = 1'b0;
    burst_cnt_n = burst_cnt_r;
    gap_cnt_n   = gap_cnt_r;
    drain_cnt_n = drain_cnt_r;
    cap         = 1'b0;
    fin         = 1'b0;
    fin_to      = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          cap         = 1'b1;
          burst_cnt_n = '0;
          gap_cnt_n   = '0;
          drain_cnt_n = '0;
          state_n     = (num_packets_i == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (reached) begin
          state_n = S_DRAIN;
        end else begin
          en_n = 1'b1;
          // Only cycles where the enable is actually high count toward the burst.
          if (node_en_o && (gap_r != '0)) begin
            if (burst_cnt_r + gap_width_p'(1) == burst_r) begin
              state_n   = S_GAP;
              en_n      = 1'b0;
              gap_cnt_n = '0;
            end else begin
              burst_cnt_n = burst_cnt_r + gap_width_p'(1);
            end
          end
        end
      end
      S_GAP: begin
        if (reached) begin
          state_n = S_DRAIN;
        end else if (gap_cnt_r == gap_r - gap_width_p'(1)) begin
          // Raise enable together with RUN re-entry so the low time is exactly gap_len.
          state_n     = S_RUN;
          en_n        = 1'b1;
          burst_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt_r + gap_width_p'(1);
        end
      end
      S_DRAIN: begin
        if (recv_d == sent_d) begin
          fin = 1'b1;
        end else if (drain_cnt_r == timeout_r) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end else begin
          drain_cnt_n = drain_cnt_r + timeout_width_p'(1);
        end
        if (fin) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= S_IDLE;
      node_en_o    <= 1'b0;
      sent_base_r  <= '0;
      recv_base_r  <= '0;
      num_r        <= '0;
      burst_r      <= '0;
      gap_r        <= '0;
      timeout_r    <= '0;
      burst_cnt_r  <= '0;
      gap_cnt_r    <= '0;
      drain_cnt_r  <= '0;
      pass_o       <= 1'b0;
      timeout_o    <= 1'b0;
      sent_count_o <= '0;
      recv_count_o <= '0;
    end else begin
      state_r     <= state_n;
      node_en_o   <= en_n;
      burst_cnt_r <= burst_cnt_n;
      gap_cnt_r   <= gap_cnt_n;
      drain_cnt_r <= drain_cnt_n;
      if (cap) begin
        sent_base_r <= node_sent_i;
        recv_base_r <= node_received_i;
        num_r       <= num_packets_i;
        burst_r     <= (burst_len_i == '0) ? gap_width_p'(1) : burst_len_i;
        gap_r       <= gap_len_i;
        timeout_r   <= timeout_i;
        pass_o      <= 1'b0;
        timeout_o   <= 1'b0;
      end
      if (fin) begin
        sent_count_o <= sent_d;
        recv_count_o <= recv_d;
        timeout_o    <= fin_to;
        pass_o       <= ~fin_to & ~node_error_i & reached;
      end
    end
  end

  assign busy_o = (state_r == S_RUN) || (state_r == S_GAP) || (state_r == S_DRAIN);
  assign done_o = (state_r == S_DONE);

endmodule
